pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the DEC→ALU pipeline register and its neighbours. It detects load-use hazards, squashes younger instructions on a taken branch, and holds the EX stage for multi-cycle mul/div operations. It freezes the whole pipe on a data-cache stall. It drives the stall, hold and flush (bubble) controls of the PC, IF_DEC, DEC_ALU and ALU_MEM registers, and keeps a stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/hold/flush sequencing with load-use, branch, mul/div and d-cache freeze
module pipe_hazard_ctrl #(
  parameter logic [6:0] OPCODE_LOAD = 7'b0000011,
  parameter int         MULDIV_LAT  = 4,
  parameter int         PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opCodeEx,
  input  logic              writeEnableEx,
  input  logic [4:0]        writeBackAddrEx,
  input  logic [4:0]        dataS1AddrDec,
  input  logic [4:0]        dataS2AddrDec,
  input  logic              useS1Dec,
  input  logic              useS2Dec,
  input  logic              isMulDivEx,
  input  logic              branchTakenEx,
  input  logic              memStall,
  output logic              pcStall,
  output logic              ifDecStall,
  output logic              ifDecFlush,
  output logic              decAluHold,
  output logic              decAluFlush,
  output logic              aluMemHold,
  output logic              mulDivDone,
  output logic [1:0]        ctrlState,
  output logic [PERF_W-1:0] stallCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Countdown start: the trigger cycle is the first stall, cnt then counts the rest down to the done cycle
  localparam logic [3:0] MD_INIT = 4'((MULDIV_LAT >= 2) ? (MULDIV_LAT - 2) : 0);
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  state_t     state;
  state_t     saved_state;
  state_t     eff_state;
  state_t     next_state;
  state_t     next_saved;
  logic [3:0] cnt;
  logic [3:0] next_cnt;
  logic       load_use;

  logic pc_stall_c, if_dec_stall_c, if_dec_flush_c;
  logic dec_alu_hold_c, dec_alu_flush_c, alu_mem_hold_c, md_done_c;

  // Load in EX whose destination feeds a source operand of the decode instruction; x0 never hazards
  always_comb begin
    load_use = (opCodeEx == OPCODE_LOAD) && writeEnableEx && (writeBackAddrEx != 5'd0) &&
               ((useS1Dec && (dataS1AddrDec == writeBackAddrEx)) ||
                (useS2Dec && (dataS2AddrDec == writeBackAddrEx)));
  end

  // Control decode and next-state; on leaving MEM_WAIT the pipe behaves as the state it froze in
  always_comb begin
    pc_stall_c      = 1'b0;
    if_dec_stall_c  = 1'b0;
    if_dec_flush_c  = 1'b0;
    dec_alu_hold_c  = 1'b0;
    dec_alu_flush_c = 1'b0;
    alu_mem_hold_c  = 1'b0;
    md_done_c       = 1'b0;
    next_state      = state;
    next_saved      = saved_state;
    next_cnt        = cnt;
    eff_state       = (state == MEM_WAIT) ? saved_state : state;

    if (memStall) begin
      pc_stall_c     = 1'b1;
      if_dec_stall_c = 1'b1;
      dec_alu_hold_c = 1'b1;
      alu_mem_hold_c = 1'b1;
      if (state != MEM_WAIT) begin
        next_saved = state;
        next_state = MEM_WAIT;
      end
    end else begin
      next_state = eff_state;
      case (eff_state)
        RUN: begin
          if (branchTakenEx) begin
            if_dec_flush_c  = 1'b1;
            dec_alu_flush_c = 1'b1;
          end else if (isMulDivEx) begin
            if (MULDIV_LAT >= 2) begin
              pc_stall_c     = 1'b1;
              if_dec_stall_c = 1'b1;
              dec_alu_hold_c = 1'b1;
              next_cnt       = MD_INIT;
              next_state     = MD_WAIT;
            end else begin
              md_done_c = 1'b1;
            end
          end else if (load_use) begin
            pc_stall_c      = 1'b1;
            if_dec_stall_c  = 1'b1;
            dec_alu_flush_c = 1'b1;
          end
        end
        MD_WAIT: begin
          if (cnt != 4'd0) begin
            pc_stall_c     = 1'b1;
            if_dec_stall_c = 1'b1;
            dec_alu_hold_c = 1'b1;
            next_cnt       = cnt - 4'd1;
          end else begin
            md_done_c  = 1'b1;
            next_state = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  // Reset forces every pipeline control low regardless of state
  always_comb begin
    pcStall     = pc_stall_c      & ~rst;
    ifDecStall  = if_dec_stall_c  & ~rst;
    ifDecFlush  = if_dec_flush_c  & ~rst;
    decAluHold  = dec_alu_hold_c  & ~rst;
    decAluFlush = dec_alu_flush_c & ~rst;
    aluMemHold  = alu_mem_hold_c  & ~rst;
    mulDivDone  = md_done_c       & ~rst;
    ctrlState   = state;
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      saved_state <= RUN;
      cnt         <= 4'd0;
    end else begin
      state       <= next_state;
      saved_state <= next_saved;
      cnt         <= next_cnt;
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount <= '0;
    end else if (pcStall && (stallCount != PERF_MAX)) begin
      stallCount <= stallCount + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and random checks of pipe_hazard_ctrl against a cycle model
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] LOAD = 7'b0000011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [6:0] opCodeEx;
  logic       writeEnableEx;
  logic [4:0] writeBackAddrEx, dataS1AddrDec, dataS2AddrDec;
  logic       useS1Dec, useS2Dec, isMulDivEx, branchTakenEx, memStall;

  logic pc_a, ids_a, idf_a, dah_a, daf_a, amh_a, mdd_a;
  logic pc_b, ids_b, idf_b, dah_b, daf_b, amh_b, mdd_b;
  logic [1:0]  st_a, st_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  pipe_hazard_ctrl #(.OPCODE_LOAD(LOAD), .MULDIV_LAT(4), .PERF_W(16)) u_a (
    .clk(clk), .rst(rst), .opCodeEx(opCodeEx), .writeEnableEx(writeEnableEx),
    .writeBackAddrEx(writeBackAddrEx), .dataS1AddrDec(dataS1AddrDec), .dataS2AddrDec(dataS2AddrDec),
    .useS1Dec(useS1Dec), .useS2Dec(useS2Dec), .isMulDivEx(isMulDivEx), .branchTakenEx(branchTakenEx),
    .memStall(memStall), .pcStall(pc_a), .ifDecStall(ids_a), .ifDecFlush(idf_a), .decAluHold(dah_a),
    .decAluFlush(daf_a), .aluMemHold(amh_a), .mulDivDone(mdd_a), .ctrlState(st_a), .stallCount(cnt_a)
  );

  pipe_hazard_ctrl #(.OPCODE_LOAD(LOAD), .MULDIV_LAT(1), .PERF_W(4)) u_b (
    .clk(clk), .rst(rst), .opCodeEx(opCodeEx), .writeEnableEx(writeEnableEx),
    .writeBackAddrEx(writeBackAddrEx), .dataS1AddrDec(dataS1AddrDec), .dataS2AddrDec(dataS2AddrDec),
    .useS1Dec(useS1Dec), .useS2Dec(useS2Dec), .isMulDivEx(isMulDivEx), .branchTakenEx(branchTakenEx),
    .memStall(memStall), .pcStall(pc_b), .ifDecStall(ids_b), .ifDecFlush(idf_b), .decAluHold(dah_b),
    .decAluFlush(daf_b), .aluMemHold(amh_b), .mulDivDone(mdd_b), .ctrlState(st_b), .stallCount(cnt_b)
  );

  wire [6:0] ctl_a = {pc_a, ids_a, idf_a, dah_a, daf_a, amh_a, mdd_a};
  wire [6:0] ctl_b = {pc_b, ids_b, idf_b, dah_b, daf_b, amh_b, mdd_b};

  int errors = 0;
  int checks = 0;

  // Model: is a mul/div in progress, how many stall cycles remain, is the pipe frozen by the d-cache
  int md_busy[2];
  int md_left[2];
  int frozen[2];
  int scnt[2];
  int lat[2] = '{4, 1};
  int pw[2]  = '{16, 4};

  function automatic logic hazard();
    return (opCodeEx == LOAD) && writeEnableEx && (writeBackAddrEx != 5'd0) &&
           ((useS1Dec && dataS1AddrDec == writeBackAddrEx) ||
            (useS2Dec && dataS2AddrDec == writeBackAddrEx));
  endfunction

  // Expected {pcStall, ifDecStall, ifDecFlush, decAluHold, decAluFlush, aluMemHold, mulDivDone}
  function automatic logic [6:0] exp_ctl(int i);
    if (rst)              return 7'b0000000;
    if (memStall)         return 7'b1101010;
    if (md_busy[i] != 0)  return (md_left[i] > 0) ? 7'b1101000 : 7'b0000001;
    if (branchTakenEx)    return 7'b0010100;
    if (isMulDivEx)       return (lat[i] == 1) ? 7'b0000001 : 7'b1101000;
    if (hazard())         return 7'b1100100;
    return 7'b0000000;
  endfunction

  function automatic void advance(int i, logic [6:0] e);
    if (rst) begin
      md_busy[i] = 0; md_left[i] = 0; frozen[i] = 0; scnt[i] = 0;
    end else begin
      if (e[6] && scnt[i] < (1 << pw[i]) - 1) scnt[i] = scnt[i] + 1;
      if (memStall) begin
        frozen[i] = 1;
      end else begin
        frozen[i] = 0;
        if (md_busy[i] != 0) begin
          if (md_left[i] > 0) md_left[i] = md_left[i] - 1;
          else md_busy[i] = 0;
        end else if (!branchTakenEx && isMulDivEx && lat[i] > 1) begin
          md_busy[i] = 1;
          md_left[i] = lat[i] - 2;
        end
      end
    end
  endfunction

  function automatic int exp_state(int i);
    return (frozen[i] != 0) ? 2 : ((md_busy[i] != 0) ? 1 : 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag);
    logic [6:0] e0, e1;
    #1;
    e0 = exp_ctl(0);
    e1 = exp_ctl(1);
    check({tag, " ctl lat4"}, 32'(ctl_a), 32'(e0));
    check({tag, " ctl lat1"}, 32'(ctl_b), 32'(e1));
    @(posedge clk);
    advance(0, e0);
    advance(1, e1);
    #1;
    check({tag, " state lat4"}, 32'(st_a), 32'(exp_state(0)));
    check({tag, " count lat4"}, 32'(cnt_a), 32'(scnt[0]));
    check({tag, " state lat1"}, 32'(st_b), 32'(exp_state(1)));
    check({tag, " count lat1"}, 32'(cnt_b), 32'(scnt[1]));
  endtask

  task automatic drive(input string tag, input logic r, input logic [6:0] op, input logic we,
                       input logic [4:0] wb, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u1, input logic u2, input logic md, input logic br, input logic ms);
    rst = r; opCodeEx = op; writeEnableEx = we; writeBackAddrEx = wb;
    dataS1AddrDec = s1; dataS2AddrDec = s2; useS1Dec = u1; useS2Dec = u2;
    isMulDivEx = md; branchTakenEx = br; memStall = ms;
    step(tag);
  endtask

  task automatic idle(input string tag);
    drive(tag, 0, 7'h33, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      md_busy[i] = 0; md_left[i] = 0; frozen[i] = 0; scnt[i] = 0;
    end

    drive("reset", 1, 7'h00, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    idle("post_reset");

    // Load-use and its non-hazard variants
    drive("load_use_rs1", 0, LOAD, 1, 5'd5, 5'd5, 5'd9, 1, 0, 0, 0, 0);
    drive("load_use_x0",  0, LOAD, 1, 5'd0, 5'd0, 5'd9, 1, 0, 0, 0, 0);
    drive("load_nouse",   0, LOAD, 1, 5'd5, 5'd5, 5'd9, 0, 0, 0, 0, 0);
    drive("load_use_rs2", 0, LOAD, 1, 5'd7, 5'd1, 5'd7, 0, 1, 0, 0, 0);
    drive("load_nowe",    0, LOAD, 0, 5'd7, 5'd7, 5'd7, 1, 1, 0, 0, 0);

    // Mul/div held for its full latency
    for (int k = 0; k < 4; k++) drive("muldiv", 0, 7'h33, 1, 5'd3, 5'd1, 5'd2, 1, 1, 1, 0, 0);
    idle("muldiv_after");

    // Branch wins over mul/div and load-use
    drive("branch_prio", 0, LOAD, 1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 1, 0);
    idle("branch_after");

    // D-cache freeze in the middle of a mul/div
    drive("md_trigger", 0, 7'h33, 1, 5'd3, 5'd1, 5'd2, 1, 1, 1, 0, 0);
    drive("md_wait1",   0, 7'h33, 1, 5'd3, 5'd1, 5'd2, 1, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) drive("mem_freeze", 0, 7'h33, 1, 5'd3, 5'd1, 5'd2, 1, 1, 0, 0, 1);
    drive("md_resume", 0, 7'h33, 1, 5'd3, 5'd1, 5'd2, 1, 1, 0, 0, 0);
    drive("md_done",   0, 7'h33, 1, 5'd3, 5'd1, 5'd2, 1, 1, 0, 0, 0);
    idle("md_idle");

    // Reset during MD_WAIT and during MEM_WAIT
    drive("md_trigger2", 0, 7'h33, 1, 5'd3, 5'd1, 5'd2, 0, 0, 1, 0, 0);
    drive("rst_in_md",   1, 7'h33, 1, 5'd3, 5'd1, 5'd2, 0, 0, 0, 0, 0);
    idle("after_rst_md");
    drive("md_trigger3", 0, 7'h33, 1, 5'd3, 5'd1, 5'd2, 0, 0, 1, 0, 0);
    drive("mem_in_md",   0, 7'h33, 1, 5'd3, 5'd1, 5'd2, 0, 0, 0, 0, 1);
    drive("rst_in_mem",  1, 7'h33, 1, 5'd3, 5'd1, 5'd2, 0, 0, 0, 0, 1);
    idle("after_rst_mem");

    // Saturation of the narrow counter
    for (int k = 0; k < 20; k++) drive("saturate", 0, 7'h33, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    idle("saturate_after");

    // Random traffic with a small register window so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      drive("random",
            ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) == 0) ? 7'($urandom) : LOAD,
            1'($urandom),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
